// File: rtl/alu_pkg.sv
// Shared definitions for the ALU and the multiply/divide sequencer:
// opcode encodings, sequencer state encoding and command constants.
package alu_pkg;

  localparam logic [2:0] ADD  = 3'b000;
  localparam logic [2:0] ADDU = 3'b001;
  localparam logic [2:0] SLL  = 3'b010;
  localparam logic [2:0] SRL  = 3'b011;
  localparam logic [2:0] SLTU = 3'b100;
  localparam logic [2:0] SUBU = 3'b101;
  localparam logic [2:0] SUB  = 3'b110;
  localparam logic [2:0] SRA  = 3'b111;

  localparam logic MUL = 1'b0;
  localparam logic DIV = 1'b1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    MUL_ADD = 3'd1,
    MUL_CRY = 3'd2,
    DIV_CMP = 3'd3,
    DIV_SUB = 3'd4,
    DONE    = 3'd5
  } seq_state_t;

endpackage

// File: rtl/alu.sv
// Combinational integer ALU shared with the core datapath.
// ADD/SUB produce the same bit patterns as ADDU/SUBU; no overflow trap here.
module alu
  import alu_pkg::*;
#(
  parameter int DATA_ALU = 32,
  parameter int OP_SZ    = 3,
  parameter int SH_SZ    = 5
) (
  input  logic [DATA_ALU-1:0] a,
  input  logic [DATA_ALU-1:0] b,
  input  logic [OP_SZ-1:0]    op,
  input  logic [SH_SZ-1:0]    shamt,
  output logic [DATA_ALU-1:0] result
);

  always_comb begin
    result = '0;
    case (op)
      ADD, ADDU: result = a + b;
      SLL:       result = a << shamt;
      SRL:       result = a >> shamt;
      SLTU:      result = {{(DATA_ALU-1){1'b0}}, (a < b)};
      SUBU, SUB: result = a - b;
      SRA:       result = $signed(a) >>> shamt;
      default:   result = '0;
    endcase
  end

endmodule

// File: rtl/alu_muldiv_seq.sv
// Sequential 32x32 unsigned multiply / 32/32 unsigned divide built on one shared alu.
// Define ALU_SEQ_DIV_EN to compile in the divide path; otherwise divide requests finish with zeros.
module alu_muldiv_seq
  import alu_pkg::*;
#(
  parameter int DATA_ALU = 32,
  parameter int OP_SZ    = 3,
  parameter int SH_SZ    = 5,
  parameter int CNT_SZ   = 6
) (
  input  logic                I_CLK,
  input  logic                I_RST,
  input  logic                I_START,
  input  logic                I_CMD,
  input  logic [DATA_ALU-1:0] I_A,
  input  logic [DATA_ALU-1:0] I_B,
  output logic                O_BUSY,
  output logic                O_DONE,
  output logic [DATA_ALU-1:0] O_LO,
  output logic [DATA_ALU-1:0] O_HI,
  output logic                O_DIV0
);

  seq_state_t state, state_next;

  // hi/lo double as remainder/quotient during a divide
  logic [DATA_ALU-1:0] hi, lo, opb, sum;
  logic [CNT_SZ-1:0]   cnt;
  logic                div0_q;
  logic                last_iter;
  logic                carry;

  logic [OP_SZ-1:0]    alu_op;
  logic [DATA_ALU-1:0] alu_a, alu_b, alu_res;

`ifdef ALU_SEQ_DIV_EN
  logic [DATA_ALU-1:0] rp;
  logic                lt;
  assign rp = {hi[DATA_ALU-2:0], lo[DATA_ALU-1]};
`endif

  assign last_iter = (cnt == CNT_SZ'(DATA_ALU-1));
  assign carry     = alu_res[0] & lo[0];

  alu #(
    .DATA_ALU(DATA_ALU),
    .OP_SZ   (OP_SZ),
    .SH_SZ   (SH_SZ)
  ) u_alu (
    .a     (alu_a),
    .b     (alu_b),
    .op    (alu_op),
    .shamt ({SH_SZ{1'b0}}),
    .result(alu_res)
  );

  always_ff @(posedge I_CLK) begin
    if (I_RST) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    alu_op     = ADDU;
    alu_a      = hi;
    alu_b      = opb;
    O_BUSY     = (state != IDLE);
    case (state)
      IDLE: begin
        if (I_START) begin
          if (I_CMD == MUL) state_next = MUL_ADD;
`ifdef ALU_SEQ_DIV_EN
          else if (I_B == '0) state_next = DONE;
          else                state_next = DIV_CMP;
`else
          else state_next = DONE;
`endif
        end
      end
      MUL_ADD: begin
        alu_op     = ADDU;
        alu_a      = hi;
        alu_b      = opb;
        state_next = MUL_CRY;
      end
      MUL_CRY: begin
        // sum < multiplicand exactly when the preceding add wrapped
        alu_op     = SLTU;
        alu_a      = sum;
        alu_b      = opb;
        state_next = last_iter ? DONE : MUL_ADD;
      end
`ifdef ALU_SEQ_DIV_EN
      DIV_CMP: begin
        alu_op     = SLTU;
        alu_a      = rp;
        alu_b      = opb;
        state_next = DIV_SUB;
      end
      DIV_SUB: begin
        alu_op     = SUBU;
        alu_a      = rp;
        alu_b      = opb;
        state_next = last_iter ? DONE : DIV_CMP;
      end
`endif
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge I_CLK) begin
    if (I_RST) begin
      hi     <= '0;
      lo     <= '0;
      opb    <= '0;
      sum    <= '0;
      cnt    <= '0;
      div0_q <= 1'b0;
      O_DONE <= 1'b0;
      O_LO   <= '0;
      O_HI   <= '0;
      O_DIV0 <= 1'b0;
`ifdef ALU_SEQ_DIV_EN
      lt     <= 1'b0;
`endif
    end else begin
      O_DONE <= 1'b0;
      case (state)
        IDLE: begin
          if (I_START) begin
            cnt    <= '0;
            opb    <= I_B;
            div0_q <= 1'b0;
            O_DIV0 <= 1'b0;
            if (I_CMD == MUL) begin
              hi <= '0;
              lo <= I_A;
            end else begin
`ifdef ALU_SEQ_DIV_EN
              if (I_B == '0) begin
                hi     <= I_A;
                lo     <= '1;
                div0_q <= 1'b1;
              end else begin
                hi <= '0;
                lo <= I_A;
              end
`else
              hi <= '0;
              lo <= '0;
`endif
            end
          end
        end
        MUL_ADD: sum <= lo[0] ? alu_res : hi;
        MUL_CRY: begin
          hi  <= {carry, sum[DATA_ALU-1:1]};
          lo  <= {sum[0], lo[DATA_ALU-1:1]};
          cnt <= cnt + 1'b1;
        end
`ifdef ALU_SEQ_DIV_EN
        // a set top bit means R' exceeds any divisor, so always subtract
        DIV_CMP: lt <= alu_res[0] & ~hi[DATA_ALU-1];
        DIV_SUB: begin
          if (!lt) begin
            hi <= alu_res;
            lo <= {lo[DATA_ALU-2:0], 1'b1};
          end else begin
            hi <= rp;
            lo <= {lo[DATA_ALU-2:0], 1'b0};
          end
          cnt <= cnt + 1'b1;
        end
`endif
        DONE: begin
          O_DONE <= 1'b1;
          O_LO   <= lo;
          O_HI   <= hi;
          O_DIV0 <= div0_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Directed bench for alu_muldiv_seq: multiply, divide, divide-by-zero, ignored starts and reset abort.
// Divide expectations follow ALU_SEQ_DIV_EN.
module tb_alu_muldiv_seq;
  import alu_pkg::*;

  logic        I_CLK = 1'b0;
  logic        I_RST;
  logic        I_START;
  logic        I_CMD;
  logic [31:0] I_A, I_B;
  logic        O_BUSY, O_DONE, O_DIV0;
  logic [31:0] O_LO, O_HI;

  int checkCount = 0;
  int passCount  = 0;
  int latency, busyCycles, doneCount;

  alu_muldiv_seq dut (
    .I_CLK  (I_CLK),
    .I_RST  (I_RST),
    .I_START(I_START),
    .I_CMD  (I_CMD),
    .I_A    (I_A),
    .I_B    (I_B),
    .O_BUSY (O_BUSY),
    .O_DONE (O_DONE),
    .O_LO   (O_LO),
    .O_HI   (O_HI),
    .O_DIV0 (O_DIV0)
  );

  always #5 I_CLK = ~I_CLK;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
  endtask

  // Launch one operation, optionally pulse I_START at two later cycles, and watch 80 cycles.
  task automatic applyStimulus(input logic cmd, input logic [31:0] a, input logic [31:0] b,
                               input int pulseA, input int pulseB,
                               output int lat, output int busyN, output int doneN);
    @(negedge I_CLK);
    I_CMD = cmd; I_A = a; I_B = b; I_START = 1'b1;
    lat = -1; busyN = 0; doneN = 0;
    for (int k = 0; k < 80; k++) begin
      @(negedge I_CLK);
      if (k == pulseA || k == pulseB) begin
        I_START = 1'b1; I_A = 32'h5555_AAAA; I_B = 32'h0000_0003;
      end else begin
        I_START = 1'b0;
      end
      if (O_BUSY) busyN++;
      if (O_DONE) begin
        doneN++;
        if (lat < 0) lat = k;
      end
    end
    I_START = 1'b0;
  endtask

  initial begin
    I_RST = 1'b1; I_START = 1'b1; I_CMD = MUL; I_A = 32'h7; I_B = 32'h6;
    repeat (2) @(negedge I_CLK);
    I_START = 1'b0;
    checkOutput("rst_busy", 32'(O_BUSY), 32'd0);
    checkOutput("rst_done", 32'(O_DONE), 32'd0);
    checkOutput("rst_lo",   O_LO, 32'h0);
    checkOutput("rst_hi",   O_HI, 32'h0);
    checkOutput("rst_div0", 32'(O_DIV0), 32'd0);
    I_RST = 1'b0;
    @(negedge I_CLK);
    checkOutput("rst_prio_busy", 32'(O_BUSY), 32'd0);

    applyStimulus(MUL, 32'd7, 32'd6, -1, -1, latency, busyCycles, doneCount);
    checkOutput("mul7x6_lat",  32'(latency), 32'd65);
    checkOutput("mul7x6_busy", 32'(busyCycles), 32'd65);
    checkOutput("mul7x6_ndone", 32'(doneCount), 32'd1);
    checkOutput("mul7x6_lo", O_LO, 32'h0000_002A);
    checkOutput("mul7x6_hi", O_HI, 32'h0000_0000);
    checkOutput("mul7x6_div0", 32'(O_DIV0), 32'd0);

    applyStimulus(MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, -1, latency, busyCycles, doneCount);
    checkOutput("mulmax_lo", O_LO, 32'h0000_0001);
    checkOutput("mulmax_hi", O_HI, 32'hFFFF_FFFE);

    applyStimulus(MUL, 32'hDEAD_BEEF, 32'h0000_0010, -1, -1, latency, busyCycles, doneCount);
    checkOutput("mulshift_lo", O_LO, 32'hEADB_EEF0);
    checkOutput("mulshift_hi", O_HI, 32'h0000_000D);

    applyStimulus(DIV, 32'd100, 32'd7, -1, -1, latency, busyCycles, doneCount);
`ifdef ALU_SEQ_DIV_EN
    checkOutput("div100_lat", 32'(latency), 32'd65);
    checkOutput("div100_lo", O_LO, 32'd14);
    checkOutput("div100_hi", O_HI, 32'd2);
`else
    checkOutput("div100_lat", 32'(latency), 32'd1);
    checkOutput("div100_lo", O_LO, 32'd0);
    checkOutput("div100_hi", O_HI, 32'd0);
`endif
    checkOutput("div100_div0", 32'(O_DIV0), 32'd0);

    applyStimulus(DIV, 32'h8000_0001, 32'hFFFF_FFFF, -1, -1, latency, busyCycles, doneCount);
`ifdef ALU_SEQ_DIV_EN
    checkOutput("divbig_lo", O_LO, 32'h0000_0000);
    checkOutput("divbig_hi", O_HI, 32'h8000_0001);
`else
    checkOutput("divbig_lo", O_LO, 32'h0);
    checkOutput("divbig_hi", O_HI, 32'h0);
`endif

    applyStimulus(DIV, 32'hFFFF_FFFF, 32'h0000_0010, -1, -1, latency, busyCycles, doneCount);
`ifdef ALU_SEQ_DIV_EN
    checkOutput("div16_lo", O_LO, 32'h0FFF_FFFF);
    checkOutput("div16_hi", O_HI, 32'h0000_000F);
`else
    checkOutput("div16_lo", O_LO, 32'h0);
    checkOutput("div16_hi", O_HI, 32'h0);
`endif

    applyStimulus(DIV, 32'h0000_1234, 32'h0, -1, -1, latency, busyCycles, doneCount);
    checkOutput("div0_lat", 32'(latency), 32'd1);
    checkOutput("div0_busy", 32'(busyCycles), 32'd1);
`ifdef ALU_SEQ_DIV_EN
    checkOutput("div0_lo", O_LO, 32'hFFFF_FFFF);
    checkOutput("div0_hi", O_HI, 32'h0000_1234);
    checkOutput("div0_flag", 32'(O_DIV0), 32'd1);
`else
    checkOutput("div0_lo", O_LO, 32'h0);
    checkOutput("div0_hi", O_HI, 32'h0);
    checkOutput("div0_flag", 32'(O_DIV0), 32'd0);
`endif

    applyStimulus(MUL, 32'd7, 32'd6, 10, 40, latency, busyCycles, doneCount);
    checkOutput("ign_ndone", 32'(doneCount), 32'd1);
    checkOutput("ign_lat", 32'(latency), 32'd65);
    checkOutput("ign_lo", O_LO, 32'h0000_002A);
    checkOutput("ign_hi", O_HI, 32'h0);
    checkOutput("ign_div0", 32'(O_DIV0), 32'd0);

    // Abort a multiply with reset, then confirm nothing completes afterwards.
    @(negedge I_CLK);
    I_CMD = MUL; I_A = 32'h0001_0000; I_B = 32'h0001_0000; I_START = 1'b1;
    @(negedge I_CLK);
    I_START = 1'b0;
    repeat (29) @(negedge I_CLK);
    checkOutput("abort_busy_pre", 32'(O_BUSY), 32'd1);
    I_RST = 1'b1;
    @(negedge I_CLK);
    I_RST = 1'b0;
    checkOutput("abort_busy", 32'(O_BUSY), 32'd0);
    checkOutput("abort_done", 32'(O_DONE), 32'd0);
    checkOutput("abort_lo", O_LO, 32'h0);
    checkOutput("abort_hi", O_HI, 32'h0);
    checkOutput("abort_div0", 32'(O_DIV0), 32'd0);
    doneCount = 0;
    for (int k = 0; k < 80; k++) begin
      @(negedge I_CLK);
      if (O_DONE) doneCount++;
    end
    checkOutput("abort_nodone", 32'(doneCount), 32'd0);

    applyStimulus(MUL, 32'd3, 32'd5, -1, -1, latency, busyCycles, doneCount);
    checkOutput("mul3x5_lo", O_LO, 32'd15);
    checkOutput("mul3x5_hi", O_HI, 32'd0);
    checkOutput("mul3x5_lat", 32'(latency), 32'd65);

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
